// File: rtl/triangle_fifo_if.sv
// triangle_fifo_if: handshake bundle between projection writer, rasteriser reader and triangle_fifo
interface triangle_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CW    = 10
);
  logic                             clear;
  logic                             wr_en;
  logic [2:0][1:0][CW-1:0]          wr_data;
  logic                             full;
  logic                             fifo_r;
  logic [2:0][1:0][CW-1:0]          triangle_data;
  logic                             fifo_empty;
  logic [$clog2(DEPTH+1)-1:0]       count;
  logic                             overflow;
  logic                             underflow;
  modport master (
    output clear, wr_en, wr_data, fifo_r,
    input  full, triangle_data, fifo_empty, count, overflow, underflow
  );
  modport slave (
    input  clear, wr_en, wr_data, fifo_r,
    output full, triangle_data, fifo_empty, count, overflow, underflow
  );
endinterface

// File: rtl/triangle_fifo.sv
// triangle_fifo: triangle buffer between projection and rasteriser with registered read data and sticky error flags
module triangle_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 10
) (
  input logic           Clk,
  input logic           Reset,
  triangle_fifo_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  logic [2:0][1:0][CW-1:0] mem [DEPTH];
  logic [2:0][1:0][CW-1:0] rd_q;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [NW-1:0]           cnt;
  logic                    ovf, unf, full, empty, wr_ok, rd_ok;
  assign full  = cnt == NW'(DEPTH);
  assign empty = cnt == '0;
  assign wr_ok = f.wr_en && !full;
  assign rd_ok = f.fifo_r && !empty;
  assign f.full          = full;
  assign f.fifo_empty    = empty;
  assign f.count         = cnt;
  assign f.triangle_data = rd_q;
  assign f.overflow      = ovf;
  assign f.underflow     = unf;
  // storage is not reset; writes are suppressed during reset and clear
  always_ff @(posedge Clk)
    if (!Reset && !f.clear && wr_ok) mem[wr_ptr] <= f.wr_data;
  // pointers, occupancy, read register and sticky flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (f.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_q   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (f.wr_en && full) ovf <= 1'b1;
      if (f.fifo_r && empty) unf <= 1'b1;
      cnt <= cnt + NW'(wr_ok) - NW'(rd_ok);
    end
  end
endmodule

// File: tb/tb_triangle_fifo.sv
// tb_triangle_fifo: directed table-driven and sequence checks of triangle_fifo
module tb_triangle_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = 10;
  typedef logic [2:0][1:0][CW-1:0] tri_t;
  typedef struct {
    logic wr, rd, clr;
    tri_t d;
    int   cnt;
    logic emp, ful, ovf, unf;
    tri_t q;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  triangle_fifo_if #(.DEPTH(DEPTH), .CW(CW)) f();
  triangle_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (.Clk(Clk), .Reset(Reset), .f(f));
  always #5 Clk = ~Clk;
  function automatic tri_t mk(int n);
    tri_t t;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 2; c++)
        t[v][c] = CW'(n * 6 + v * 2 + c + 1);
    return t;
  endfunction
  function automatic vec_t row(logic wr, logic rd, logic clr, tri_t d, int cnt,
                               logic emp, logic ful, logic ovf, logic unf, tri_t q);
    vec_t r;
    r.wr = wr; r.rd = rd; r.clr = clr; r.d = d; r.cnt = cnt;
    r.emp = emp; r.ful = ful; r.ovf = ovf; r.unf = unf; r.q = q;
    return r;
  endfunction
  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic drive(logic wr, logic rd, logic clr, tri_t d);
    f.wr_en = wr; f.fifo_r = rd; f.clear = clr; f.wr_data = d;
    @(posedge Clk);
    #1;
    f.wr_en = 1'b0; f.fifo_r = 1'b0; f.clear = 1'b0;
  endtask
  task automatic st(string tag, int cnt, logic emp, logic ful, logic ovf, logic unf, tri_t q);
    chk({tag, ".count"}, 64'(f.count), 64'(cnt));
    chk({tag, ".empty"}, 64'(f.fifo_empty), 64'(emp));
    chk({tag, ".full"}, 64'(f.full), 64'(ful));
    chk({tag, ".overflow"}, 64'(f.overflow), 64'(ovf));
    chk({tag, ".underflow"}, 64'(f.underflow), 64'(unf));
    chk({tag, ".data"}, 64'(f.triangle_data), 64'(q));
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask
  vec_t tbl[$];
  initial begin
    tri_t z = '0;
    f.wr_en = 1'b0; f.fifo_r = 1'b0; f.clear = 1'b0; f.wr_data = '0;
    // basic order, underflow, clear with a concurrent write, post-clear traffic
    tbl.push_back(row(1, 0, 0, mk(1), 1, 0, 0, 0, 0, z));
    tbl.push_back(row(1, 0, 0, mk(2), 2, 0, 0, 0, 0, z));
    tbl.push_back(row(1, 0, 0, mk(3), 3, 0, 0, 0, 0, z));
    tbl.push_back(row(0, 1, 0, z, 2, 0, 0, 0, 0, mk(1)));
    tbl.push_back(row(0, 1, 0, z, 1, 0, 0, 0, 0, mk(2)));
    tbl.push_back(row(0, 1, 0, z, 0, 1, 0, 0, 0, mk(3)));
    tbl.push_back(row(0, 1, 0, z, 0, 1, 0, 0, 1, mk(3)));
    for (int i = 0; i < 7; i++)
      tbl.push_back(row(1, 0, 0, mk(10 + i), i + 1, 0, 0, 0, 1, mk(3)));
    tbl.push_back(row(1, 0, 1, mk(50), 0, 1, 0, 0, 0, mk(3)));
    tbl.push_back(row(1, 0, 0, mk(60), 1, 0, 0, 0, 0, mk(3)));
    tbl.push_back(row(0, 1, 0, z, 0, 1, 0, 0, 0, mk(60)));
    do_reset();
    st("reset", 0, 1, 0, 0, 0, z);
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].d);
      st($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].unf, tbl[i].q);
    end
    // fill to full, drop the seventeenth write, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, mk(20 + i));
      chk($sformatf("fill%0d.full", i), 64'(f.full), 64'(i == 15));
    end
    drive(1, 0, 0, mk(36));
    st("overfill", 16, 0, 1, 1, 0, z);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, z);
      chk($sformatf("drain%0d.data", i), 64'(f.triangle_data), 64'(mk(20 + i)));
      chk($sformatf("drain%0d.count", i), 64'(f.count), 64'(15 - i));
    end
    // read while empty holds data and sets underflow
    drive(0, 1, 0, z);
    st("empty_rd", 0, 1, 0, 1, 1, mk(35));
    // simultaneous read and write on an empty fifo: write only
    do_reset();
    drive(1, 1, 0, mk(70));
    st("empty_rw", 1, 0, 0, 0, 1, z);
    drive(0, 1, 0, z);
    chk("empty_rw.data", 64'(f.triangle_data), 64'(mk(70)));
    // steady state at count 5 with concurrent read/write, pointers wrapping
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, mk(100 + i));
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 0, mk(105 + i));
      chk($sformatf("rw%0d.data", i), 64'(f.triangle_data), 64'(mk(100 + i)));
      chk($sformatf("rw%0d.count", i), 64'(f.count), 64'd5);
    end
    // simultaneous read and write on a full fifo: read only
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 0, 0, mk(150 + i));
    drive(1, 1, 0, mk(170));
    st("full_rw", 15, 0, 0, 1, 0, mk(150));
    // reset in the middle of a burst discards everything
    drive(1, 1, 0, mk(171));
    Reset = 1'b1;
    drive(1, 1, 0, mk(172));
    Reset = 1'b0;
    st("mid_reset", 0, 1, 0, 0, 0, z);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
